// File: rtl/sar_word_deser.sv
// Rebuilds parallel BITS-bit conversion words from the SAR logic's MSB-first serial result stream
// and queues them in a first-word-fall-through FIFO behind a valid/ready interface.
module sar_word_deser #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       XRST,
    input  logic                       COMP_CLK,
    input  logic                       DIGITAL_OUT,
    input  logic [BITS:0]              SDAC,
    output logic [BITS-1:0]            WORD_DATA,
    output logic                       WORD_VALID,
    input  logic                       WORD_READY,
    output logic [$clog2(DEPTH+1)-1:0] FIFO_LEVEL,
    output logic                       FRAME_ACTIVE,
    output logic                       OVERRUN,
    output logic                       SYNC_ERR,
    input  logic                       CLR_ERR
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(BITS);
    localparam logic [BITS:0]   MARK = {1'b1, {BITS{1'b0}}};
    localparam logic [CW-1:0]   LAST = CW'(BITS - 1);
    localparam logic [LW-1:0]   FULL = LW'(DEPTH);

    typedef enum logic {StHunt, StActive} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [BITS-2:0] shreg_q;
    logic            cc_q;
    logic            mark_q;

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            overrun_q;
    logic            sync_err_q;

    logic            rise;
    logic            fall;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            sync_hit;
    logic [BITS-1:0] push_word;

    assign rise      = COMP_CLK & ~cc_q;
    assign fall      = ~COMP_CLK & cc_q;
    assign push_word = {shreg_q, DIGITAL_OUT};
    assign push      = fall & ~mark_q & (state_q == StActive) & (cnt_q == LAST);
    assign sync_hit  = fall & mark_q & (state_q == StActive);
    assign full      = (level_q == FULL);
    assign pop       = (level_q != '0) & WORD_READY;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign wr_en     = push & (~full | pop);

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            state_q <= StHunt;
            cnt_q   <= '0;
            shreg_q <= '0;
            cc_q    <= 1'b0;
            mark_q  <= 1'b0;
        end else begin
            cc_q <= COMP_CLK;
            if (rise) begin
                mark_q <= (SDAC == MARK);
            end
            if (fall) begin
                if (mark_q) begin
                    // A marker always (re)starts a frame, mid-frame or not.
                    shreg_q <= {{(BITS - 2){1'b0}}, DIGITAL_OUT};
                    cnt_q   <= CW'(1);
                    state_q <= StActive;
                end else if (state_q == StActive) begin
                    shreg_q <= {shreg_q[BITS-3:0], DIGITAL_OUT};
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= StHunt;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (push & ~wr_en) begin
                overrun_q <= 1'b1;
            end else if (CLR_ERR) begin
                overrun_q <= 1'b0;
            end
            if (sync_hit) begin
                sync_err_q <= 1'b1;
            end else if (CLR_ERR) begin
                sync_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign WORD_VALID   = (level_q != '0);
    assign WORD_DATA    = WORD_VALID ? mem[rd_ptr_q] : '0;
    assign FIFO_LEVEL   = level_q;
    assign FRAME_ACTIVE = (state_q == StActive);
    assign OVERRUN      = overrun_q;
    assign SYNC_ERR     = sync_err_q;

endmodule
